axis_prbs_gen: RTL and testbench

Parametrised AXI-stream pseudorandom (PRBS) source; successor to the fixed 32-bit free-running LFSR stream generator.
- Adds runtime-selectable polynomial, loadable seed, start/stop control, and packet framing via TLAST.
- Advances the LFSR DW bits per accepted beat.
- Feeds link BIST, DMA soak tests and checker benches elsewhere in the design.

---
 rtl/axis_prbs_pkg.sv | 45 ++++
 rtl/prbs_advance.sv | 36 +++
 rtl/axis_prbs_gen.sv | 174 +++++++++++++++++
 tb/tb_axis_prbs_gen.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_prbs_pkg.sv
// Shared types and polynomial constants for the AXI-stream PRBS generator.
package axis_prbs_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    // Polynomial order / second tap, x^ORDER + x^TAP + 1
    localparam int ORDER_PRBS7  = 7;
    localparam int TAP_PRBS7    = 6;
    localparam int ORDER_PRBS15 = 15;
    localparam int TAP_PRBS15   = 14;
    localparam int ORDER_PRBS23 = 23;
    localparam int TAP_PRBS23   = 18;
    localparam int ORDER_PRBS31 = 31;
    localparam int TAP_PRBS31   = 28;

    // Keeps only the state bits that belong to the selected polynomial.
    function automatic logic [30:0] prbs_mask(prbs_mode_e m);
        logic [30:0] mask;
        unique case (m)
            MODE_PRBS7:  mask = 31'h0000_007F;
            MODE_PRBS15: mask = 31'h0000_7FFF;
            MODE_PRBS23: mask = 31'h007F_FFFF;
            default:     mask = 31'h7FFF_FFFF;
        endcase
        return mask;
    endfunction

    // A zero state would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [30:0] prbs_seed_fix(logic [30:0] seed, prbs_mode_e m);
        logic [30:0] masked;
        masked = seed & prbs_mask(m);
        return (masked == '0) ? prbs_mask(m) : masked;
    endfunction

endpackage

// File: rtl/prbs_advance.sv
// Combinational DW-step advance of a Fibonacci LFSR; first bit lands in bits_o[DW-1].
module prbs_advance
    import axis_prbs_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [30:0]   state_i,
    input  prbs_mode_e    mode_i,
    output logic [DW-1:0] bits_o,
    output logic [30:0]   next_o
);

    logic [30:0] s;
    logic        b;
    logic [30:0] mask;

    // Unrolled DW-step walk; bits shift in from the LSB so the first ends at the MSB.
    always_comb begin
        mask   = prbs_mask(mode_i);
        s      = state_i & mask;
        b      = 1'b0;
        bits_o = '0;
        for (int i = 0; i < DW; i++) begin
            unique case (mode_i)
                MODE_PRBS7:  b = s[ORDER_PRBS7-1]  ^ s[TAP_PRBS7-1];
                MODE_PRBS15: b = s[ORDER_PRBS15-1] ^ s[TAP_PRBS15-1];
                MODE_PRBS23: b = s[ORDER_PRBS23-1] ^ s[TAP_PRBS23-1];
                default:     b = s[ORDER_PRBS31-1] ^ s[TAP_PRBS31-1];
            endcase
            bits_o = {bits_o[DW-2:0], b};
            s      = {s[29:0], b} & mask;
        end
        next_o = s;
    end

endmodule

// File: rtl/axis_prbs_gen.sv
// AXI-stream PRBS source with selectable polynomial, seed, packet framing and stop.
// Optional single-beat bit-0 error injection: define AXISPRBS_ERRINJ_EN.
module axis_prbs_gen
    import axis_prbs_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LGPKT = 16
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [30:0]      i_seed,
    input  logic [LGPKT-1:0] i_pkt_len,
`ifdef AXISPRBS_ERRINJ_EN
    input  logic             i_err_inj,
`endif
    output logic             M_AXIS_TVALID,
    input  logic             M_AXIS_TREADY,
    output logic [DW-1:0]    M_AXIS_TDATA,
    output logic             M_AXIS_TLAST,
    output logic             o_busy
);

    gen_state_e       state_q, state_d;
    prbs_mode_e       mode_q, mode_d;
    logic [LGPKT-1:0] len_q, len_d;
    logic [LGPKT-1:0] cnt_q, cnt_d;
    logic [LGPKT-1:0] cnt_inc;
    logic [30:0]      lfsr_q, lfsr_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             stop_pend_q, stop_pend_d;
    logic             load;
    logic             inj_flip;

    logic [30:0]      adv_state;
    prbs_mode_e       adv_mode;
    logic [DW-1:0]    adv_bits;
    logic [30:0]      adv_next;

`ifdef AXISPRBS_ERRINJ_EN
    logic             err_arm_q, err_arm_d;
`endif

    // In IDLE the advancer runs from the incoming seed/mode so start can load beat 0.
    always_comb begin
        adv_mode  = mode_q;
        adv_state = lfsr_q;
        if (state_q == ST_IDLE) begin
            adv_mode  = prbs_mode_e'(i_mode);
            adv_state = prbs_seed_fix(i_seed, prbs_mode_e'(i_mode));
        end
    end

    prbs_advance #(.DW(DW)) u_adv (
        .state_i (adv_state),
        .mode_i  (adv_mode),
        .bits_o  (adv_bits),
        .next_o  (adv_next)
    );

    // Next-state, framing and beat-load decisions.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        stop_pend_d = stop_pend_q;
        load        = 1'b0;
        cnt_inc     = cnt_q + 1'b1;
`ifdef AXISPRBS_ERRINJ_EN
        inj_flip    = err_arm_q | i_err_inj;
        err_arm_d   = inj_flip;
`else
        inj_flip    = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_RUN;
                    mode_d      = prbs_mode_e'(i_mode);
                    len_d       = i_pkt_len;
                    cnt_d       = '0;
                    tlast_d     = (i_pkt_len == '0);
                    tvalid_d    = 1'b1;
                    stop_pend_d = i_stop;
                    load        = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tvalid_q && M_AXIS_TREADY) begin
                    if (tlast_q && (stop_pend_q || i_stop)) begin
                        state_d     = ST_IDLE;
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tdata_d     = '0;
                        cnt_d       = '0;
                        stop_pend_d = 1'b0;
                    end else if (tlast_q) begin
                        cnt_d   = '0;
                        tlast_d = (len_q == '0);
                        load    = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                        tlast_d = (cnt_inc == len_q);
                        load    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            lfsr_d  = adv_next;
            tdata_d = {adv_bits[DW-1:1], adv_bits[0] ^ inj_flip};
`ifdef AXISPRBS_ERRINJ_EN
            err_arm_d = 1'b0;
`endif
        end
    end

    // State and stream registers.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_PRBS7;
            len_q       <= '0;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            stop_pend_q <= stop_pend_d;
        end
    end

`ifdef AXISPRBS_ERRINJ_EN
    // One-shot injection arm; survives IDLE until a beat is loaded.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            err_arm_q <= 1'b0;
        end else begin
            err_arm_q <= err_arm_d;
        end
    end
`endif

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign o_busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_axis_prbs_gen.sv
// Directed scoreboard bench for axis_prbs_gen (DW=8).
module tb_axis_prbs_gen;

    localparam int DW    = 8;
    localparam int LGPKT = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [30:0]      seed;
    logic [LGPKT-1:0] pkt_len;
    logic             err_inj;
    logic             tvalid;
    logic             tready;
    logic [DW-1:0]    tdata;
    logic             tlast;
    logic             busy;

    beat_t exp_q[$];
    int    total;
    int    bad;
    int    acc_cnt;
    bit    pat_en;

    axis_prbs_gen #(.DW(DW), .LGPKT(LGPKT)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_mode        (mode),
        .i_seed        (seed),
        .i_pkt_len     (pkt_len),
`ifdef AXISPRBS_ERRINJ_EN
        .i_err_inj     (err_inj),
`endif
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TLAST  (tlast),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference: x^n + x^t + 1, output bit is the feedback bit.
    task automatic push_beats(input logic [1:0] m, input logic [30:0] sd, input int len,
                              input int nbeats, input int flip_idx);
        int          n;
        int          t;
        logic [30:0] mask;
        logic [30:0] st;
        logic        b;
        beat_t       bt;
        case (m)
            2'd0:    begin n = 7;  t = 6;  end
            2'd1:    begin n = 15; t = 14; end
            2'd2:    begin n = 23; t = 18; end
            default: begin n = 31; t = 28; end
        endcase
        mask = 31'h7FFF_FFFF;
        mask = mask >> (31 - n);
        st   = sd & mask;
        if (st == 0) st = mask;
        for (int k = 0; k < nbeats; k++) begin
            bt.data = '0;
            for (int j = 0; j < DW; j++) begin
                b       = st[n-1] ^ st[t-1];
                bt.data = {bt.data[DW-2:0], b};
                st      = ((st << 1) | {30'd0, b}) & mask;
            end
            if (k == flip_idx) bt.data[0] = ~bt.data[0];
            bt.last = ((k % (len + 1)) == len);
            exp_q.push_back(bt);
        end
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("acc_reached", 64'(acc_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [30:0] sd, input int len,
                            input logic with_stop);
        mode    = m;
        seed    = sd;
        pkt_len = LGPKT'(len);
        start   = 1'b1;
        stop    = with_stop;
        acc_cnt = 0;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
        mode    = ~m;
        seed    = ~sd;
        pkt_len = '1;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_tvalid_low"}, 64'(tvalid), 64'd0);
    endtask

    initial begin
        int pi;
        int pat[4] = '{1, 0, 0, 1};
        beat_t bt;

        total   = 0;
        bad     = 0;
        acc_cnt = 0;
        pat_en  = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'd0;
        seed    = '0;
        pkt_len = '0;
        err_inj = 1'b0;
        tready  = 1'b0;

        fork
            // Monitor: pops the scoreboard on each accepted beat, peeks while stalled.
            forever begin
                @(negedge clk);
                if (!rst && tvalid) begin
                    chk("busy_with_valid", 64'(busy), 64'd1);
                    if (tready) begin
                        total++;
                        assert (exp_q.size() > 0) else begin
                            bad++;
                            $error("FAIL unexpected_beat observed=%0h expected=none", tdata);
                        end
                        if (exp_q.size() > 0) begin
                            bt = exp_q.pop_front();
                            chk("beat_data", 64'(tdata), 64'(bt.data));
                            chk("beat_last", 64'(tlast), 64'(bt.last));
                        end
                        acc_cnt++;
                    end else if (exp_q.size() > 0) begin
                        chk("stall_data", 64'(tdata), 64'(exp_q[0].data));
                        chk("stall_last", 64'(tlast), 64'(exp_q[0].last));
                    end
                end
            end
            // Ready pattern generator for the stall test.
            begin
                pi = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (pat_en) begin
                        tready = pat[pi][0];
                        pi     = (pi + 1) % 4;
                    end
                end
            end
        join_none

        repeat (3) tick();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Stop in IDLE is ignored.
        pulse_stop();
        chk("idle_stop_ignored", 64'(busy), 64'd0);

        // PRBS7, seed 7F, 4-beat packets, free-flowing sink.
        tready = 1'b1;
        push_beats(2'd0, 31'h7F, 3, 12, -1);
        do_start(2'd0, 31'h7F, 3, 1'b0);
        chk("first_valid", 64'(tvalid), 64'd1);
        chk("first_data", 64'(tdata), 64'h02);
        chk("first_busy", 64'(busy), 64'd1);
        wait_acc(9, 50);
        pulse_stop();
        wait_idle(50);
        end_checks("flow");

        // Same stream with ready toggling 1,0,0,1.
        tready = 1'b0;
        push_beats(2'd0, 31'h7F, 3, 12, -1);
        pat_en = 1'b1;
        do_start(2'd0, 31'h7F, 3, 1'b0);
        wait_acc(9, 100);
        pulse_stop();
        wait_idle(100);
        pat_en = 1'b0;
        tick();
        tready = 1'b1;
        end_checks("stall");

        // Zero seed behaves as all-ones; one full 127-beat packet; start+stop together.
        push_beats(2'd0, 31'h0, 126, 127, -1);
        do_start(2'd0, 31'h0, 126, 1'b1);
        chk("zero_seed_first", 64'(tdata), 64'h02);
        wait_idle(300);
        end_checks("zero_seed");

        // Stop raised on beat 1 of a 4-beat packet (PRBS15).
        push_beats(2'd1, 31'h1234, 3, 4, -1);
        do_start(2'd1, 31'h1234, 3, 1'b0);
        tick();
        pulse_stop();
        wait_idle(50);
        end_checks("mid_stop");
        chk("mid_stop_busy", 64'(busy), 64'd0);

        // PRBS23, single-beat packets, stop arriving on the final TLAST beat.
        push_beats(2'd2, 31'h5A5A5A, 0, 6, -1);
        do_start(2'd2, 31'h5A5A5A, 0, 1'b0);
        wait_acc(5, 50);
        pulse_stop();
        wait_idle(50);
        end_checks("prbs23");

        // PRBS31, 3-beat packets.
        push_beats(2'd3, 31'h6BCD1234, 2, 6, -1);
        do_start(2'd3, 31'h6BCD1234, 2, 1'b0);
        wait_acc(4, 50);
        pulse_stop();
        wait_idle(50);
        end_checks("prbs31");

        // Asynchronous reset between edges while stalled.
        tready = 1'b0;
        push_beats(2'd1, 31'h7777, 3, 4, -1);
        do_start(2'd1, 31'h7777, 3, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(tvalid), 64'd0);
        chk("arst_tdata", 64'(tdata), 64'd0);
        chk("arst_tlast", 64'(tlast), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tready = 1'b1;
        push_beats(2'd0, 31'h7F, 3, 4, -1);
        do_start(2'd0, 31'h7F, 3, 1'b1);
        chk("arst_restart_data", 64'(tdata), 64'h02);
        wait_idle(50);
        end_checks("arst_restart");

`ifdef AXISPRBS_ERRINJ_EN
        // Two injection pulses while beat 0 stalls: only beat 1 gets bit 0 flipped.
        tready = 1'b0;
        push_beats(2'd1, 31'h0ACE, 3, 4, 1);
        do_start(2'd1, 31'h0ACE, 3, 1'b0);
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        tick();
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        tready  = 1'b1;
        pulse_stop();
        wait_idle(50);
        end_checks("errinj");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
